// File: rtl/mc_pkg.sv
// Shared definitions for the phase-select sequencer: load codes, the
// sequencer state encoding, default parameters and the state-to-load mapping.
package mc_pkg;

  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] LAA = 2'b01;
  localparam logic [1:0] LBB = 2'b10;
  localparam logic [1:0] LCC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN_A = 2'd1,
    S_RUN_B = 2'd2,
    S_RUN_C = 2'd3
  } seq_state_e;

  localparam int PERIOD_W_DEF = 12;
  localparam int SAMP_W_DEF   = 12;
  localparam int HYST_DEF     = 16;
  localparam int DEBOUNCE_DEF = 3;

  function automatic logic [1:0] load_code(input seq_state_e s);
    case (s)
      S_RUN_A: return LAA;
      S_RUN_B: return LBB;
      S_RUN_C: return LCC;
      default: return NUL;
    endcase
  endfunction

endpackage

// File: rtl/phase_select_sequencer_sign_detector.sv
// Load-current sign detector with a symmetric hysteresis band and a
// consecutive-vote debounce before the reported sign is allowed to flip.
module sign_detector #(
  parameter int SAMP_W   = 12,
  parameter int HYST     = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SAMP_W-1:0] isample,
  input  logic                     isample_valid,
  output logic                     current_sign
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic signed [SAMP_W-1:0] HI = SAMP_W'(HYST);
  localparam logic signed [SAMP_W-1:0] LO = -HI;

  logic [CW-1:0] votes;
  logic          above;
  logic          below;
  logic          opposite;

  always_comb begin
    above    = isample > HI;
    below    = isample < LO;
    // In-band samples and samples agreeing with the current sign both break the run.
    opposite = above ? !current_sign : (below && current_sign);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_sign <= 1'b0;
      votes        <= '0;
    end else if (isample_valid) begin
      if (!opposite) begin
        votes <= '0;
      end else if (votes == CW'(DEBOUNCE - 1)) begin
        current_sign <= ~current_sign;
        votes        <= '0;
      end else begin
        votes <= votes + 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_select_sequencer.sv
// Carrier-period sequencer selecting source A/B/C dwell phases from a buffered
// duty set. Define SEQ_ALTERNATE_EN to run odd periods in C, B, A order.
module phase_select_sequencer
  import mc_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int SAMP_W   = SAMP_W_DEF,
  parameter int HYST     = HYST_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     duty_valid,
  output logic                     duty_ready,
  input  logic [PERIOD_W-1:0]      period,
  input  logic [PERIOD_W-1:0]      duty_a,
  input  logic [PERIOD_W-1:0]      duty_b,
  input  logic signed [SAMP_W-1:0] isample,
  input  logic                     isample_valid,
  output logic [1:0]               desired_load,
  output logic                     current_sign,
  output logic                     period_start,
  output logic                     fault
);

  logic [PERIOD_W-1:0] buf_period, buf_da, buf_db;
  logic                buf_full;
  logic [PERIOD_W-1:0] period_sh, da_sh, db_sh;
  logic                sh_valid;
  seq_state_e          state, state_nx;
  logic [PERIOD_W-1:0] cnt, cnt_nx;
  logic [PERIOD_W-1:0] da_nx, db_nx;
  logic                run_nx, load_sh, xfer, reject, wrap;

`ifdef SEQ_ALTERNATE_EN
  logic                parity, parity_nx;
  logic [PERIOD_W-1:0] p_nx;

  function automatic seq_state_e phase_of(input logic [PERIOD_W-1:0] c, p, a, b,
                                          input logic odd);
    logic [PERIOD_W:0] ce, ab, dc;
    ce = {1'b0, c};
    ab = {1'b0, a} + {1'b0, b};
    dc = {1'b0, p} - ab;
    if (!odd) begin
      if (ce < {1'b0, a}) return S_RUN_A;
      if (ce < ab)        return S_RUN_B;
      return S_RUN_C;
    end
    if (ce < dc)                     return S_RUN_C;
    if (ce < {1'b0, p} - {1'b0, a})  return S_RUN_B;
    return S_RUN_A;
  endfunction
`else
  function automatic seq_state_e phase_of(input logic [PERIOD_W-1:0] c, a, b);
    logic [PERIOD_W:0] ce, ab;
    ce = {1'b0, c};
    ab = {1'b0, a} + {1'b0, b};
    if (ce < {1'b0, a}) return S_RUN_A;
    if (ce < ab)        return S_RUN_B;
    return S_RUN_C;
  endfunction
`endif

  assign duty_ready = !buf_full;

  always_comb begin
    xfer    = duty_valid && !buf_full;
    // Sum is formed one bit wider so large duty pairs cannot wrap into range.
    reject  = xfer && ((({1'b0, duty_a} + {1'b0, duty_b}) > {1'b0, period}) ||
                       (period < PERIOD_W'(2)));
    wrap    = (state != S_IDLE) && (cnt == period_sh - PERIOD_W'(1));
    run_nx  = 1'b0;
    load_sh = 1'b0;
    cnt_nx  = '0;
`ifdef SEQ_ALTERNATE_EN
    parity_nx = parity;
`endif
    if (enable) begin
      if (state == S_IDLE) begin
        if (sh_valid || buf_full) begin
          run_nx  = 1'b1;
          load_sh = buf_full;
`ifdef SEQ_ALTERNATE_EN
          parity_nx = 1'b0;
`endif
        end
      end else begin
        run_nx = 1'b1;
        if (wrap) begin
          load_sh = buf_full;
`ifdef SEQ_ALTERNATE_EN
          parity_nx = ~parity;
`endif
        end else begin
          cnt_nx = cnt + PERIOD_W'(1);
        end
      end
    end
    da_nx    = load_sh ? buf_da : da_sh;
    db_nx    = load_sh ? buf_db : db_sh;
    state_nx = S_IDLE;
`ifdef SEQ_ALTERNATE_EN
    p_nx = load_sh ? buf_period : period_sh;
    if (run_nx) state_nx = phase_of(cnt_nx, p_nx, da_nx, db_nx, parity_nx);
`else
    if (run_nx) state_nx = phase_of(cnt_nx, da_nx, db_nx);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      desired_load <= NUL;
      period_start <= 1'b0;
      fault        <= 1'b0;
      buf_full     <= 1'b0;
      buf_period   <= '0;
      buf_da       <= '0;
      buf_db       <= '0;
      sh_valid     <= 1'b0;
      period_sh    <= '0;
      da_sh        <= '0;
      db_sh        <= '0;
`ifdef SEQ_ALTERNATE_EN
      parity       <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      // Load code trails the state by one cycle, but disable forces NUL at once.
      desired_load <= enable ? load_code(state) : NUL;
      period_start <= run_nx && (cnt_nx == '0);
      fault        <= reject;
`ifdef SEQ_ALTERNATE_EN
      parity       <= parity_nx;
`endif
      if (load_sh) begin
        period_sh <= buf_period;
        da_sh     <= buf_da;
        db_sh     <= buf_db;
        sh_valid  <= 1'b1;
      end
      if (xfer && !reject) begin
        buf_period <= period;
        buf_da     <= duty_a;
        buf_db     <= duty_b;
        buf_full   <= 1'b1;
      end else if (load_sh) begin
        buf_full <= 1'b0;
      end
    end
  end

  sign_detector #(
    .SAMP_W  (SAMP_W),
    .HYST    (HYST),
    .DEBOUNCE(DEBOUNCE)
  ) u_sign (
    .clk          (clk),
    .rst          (rst),
    .isample      (isample),
    .isample_valid(isample_valid),
    .current_sign (current_sign)
  );

endmodule

// File: tb/tb_phase_select_sequencer.sv
// Directed bench for phase_select_sequencer: sequence, skip/reject, buffered
// update, sign detector, disable and asynchronous reset scenarios.
module tb_phase_select_sequencer;

  localparam int PW = 12;
  localparam int SW = 12;
  localparam logic [1:0] C_NUL = 2'b00;
  localparam logic [1:0] C_LAA = 2'b01;
  localparam logic [1:0] C_LBB = 2'b10;
  localparam logic [1:0] C_LCC = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 enable = 1'b0;
  logic                 duty_valid = 1'b0;
  logic                 duty_ready;
  logic [PW-1:0]        period = '0;
  logic [PW-1:0]        duty_a = '0;
  logic [PW-1:0]        duty_b = '0;
  logic signed [SW-1:0] isample = '0;
  logic                 isample_valid = 1'b0;
  logic [1:0]           desired_load;
  logic                 current_sign;
  logic                 period_start;
  logic                 fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_select_sequencer #(
    .PERIOD_W(PW),
    .SAMP_W  (SW),
    .HYST    (16),
    .DEBOUNCE(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .period       (period),
    .duty_a       (duty_a),
    .duty_b       (duty_b),
    .isample      (isample),
    .isample_valid(isample_valid),
    .desired_load (desired_load),
    .current_sign (current_sign),
    .period_start (period_start),
    .fault        (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    duty_valid = 1'b0;
    isample_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send_duty(input int p, input int a, input int b);
    period = PW'(p);
    duty_a = PW'(a);
    duty_b = PW'(b);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
  endtask

  task automatic pulse_sample(input int v);
    isample = SW'(v);
    isample_valid = 1'b1;
    step();
    isample_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1;
    #1;
    checks++; if (desired_load !== C_NUL) begin errors++; $display("FAIL rst_load got=%0d exp=%0d", desired_load, C_NUL); end
    checks++; if (current_sign !== 1'b0) begin errors++; $display("FAIL rst_sign got=%0b exp=0", current_sign); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%0b exp=0", fault); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_pstart got=%0b exp=0", period_start); end
    checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", duty_ready); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] exp;
    logic odd;
    int pos;
    do_reset();
    send_duty(10, 3, 3);
    enable = 1'b1;
    step();
    checks++; if (period_start !== 1'b1 || desired_load !== C_NUL) begin errors++; $display("FAIL basic_entry got=%0b/%0d exp=1/%0d", period_start, desired_load, C_NUL); end
    for (int k = 0; k < 20; k++) begin
      step();
      pos = k % 10;
`ifdef SEQ_ALTERNATE_EN
      odd = ((k / 10) % 2) == 1;
`else
      odd = 1'b0;
`endif
      if (!odd) exp = (pos < 3) ? C_LAA : (pos < 6) ? C_LBB : C_LCC;
      else      exp = (pos < 4) ? C_LCC : (pos < 7) ? C_LBB : C_LAA;
      checks++; if (desired_load !== exp) begin errors++; $display("FAIL basic_load[%0d] got=%0d exp=%0d", k, desired_load, exp); end
      checks++; if (period_start !== (pos == 9)) begin errors++; $display("FAIL basic_pstart[%0d] got=%0b exp=%0b", k, period_start, pos == 9); end
    end
  endtask

  task automatic test_zero_skip_reject();
    do_reset();
    send_duty(10, 0, 10);
    enable = 1'b1;
    step();
    checks++; if (desired_load !== C_NUL) begin errors++; $display("FAIL zero_entry got=%0d exp=%0d", desired_load, C_NUL); end
    for (int k = 0; k < 15; k++) begin
      step();
      checks++; if (desired_load !== C_LBB) begin errors++; $display("FAIL zero_load[%0d] got=%0d exp=%0d", k, desired_load, C_LBB); end
    end
    checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%0b exp=1", duty_ready); end
    send_duty(10, 6, 5);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rej_sum_fault got=%0b exp=1", fault); end
    checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL rej_sum_ready got=%0b exp=1", duty_ready); end
    step();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rej_fault_pulse got=%0b exp=0", fault); end
    send_duty(1, 0, 0);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rej_short_fault got=%0b exp=1", fault); end
    step();
    send_duty(10, 4095, 2);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rej_wrap_fault got=%0b exp=1", fault); end
    checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL rej_wrap_ready got=%0b exp=1", duty_ready); end
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (desired_load !== C_LBB || fault !== 1'b0) begin errors++; $display("FAIL zero_after[%0d] got=%0d/%0b exp=%0d/0", k, desired_load, fault, C_LBB); end
    end
  endtask

  task automatic test_mid_update();
    logic [1:0] exp;
    do_reset();
    send_duty(10, 3, 3);
    enable = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_pre got=%0b exp=1", duty_ready); end
    send_duty(10, 5, 2);
    checks++; if (duty_ready !== 1'b0 || desired_load !== C_LBB) begin errors++; $display("FAIL mid_xfer got=%0b/%0d exp=0/%0d", duty_ready, desired_load, C_LBB); end
    for (int c = 5; c <= 9; c++) begin
      step();
      exp = ((c - 1) < 6) ? C_LBB : C_LCC;
      checks++; if (duty_ready !== 1'b0 || desired_load !== exp) begin errors++; $display("FAIL mid_old[%0d] got=%0b/%0d exp=0/%0d", c, duty_ready, desired_load, exp); end
    end
    step();
    checks++; if (duty_ready !== 1'b1 || period_start !== 1'b1 || desired_load !== C_LCC) begin errors++; $display("FAIL mid_wrap got=%0b/%0b/%0d exp=1/1/%0d", duty_ready, period_start, desired_load, C_LCC); end
    for (int k = 0; k < 10; k++) begin
      step();
`ifdef SEQ_ALTERNATE_EN
      exp = (k < 3) ? C_LCC : (k < 5) ? C_LBB : C_LAA;
`else
      exp = (k < 5) ? C_LAA : (k < 7) ? C_LBB : C_LCC;
`endif
      checks++; if (desired_load !== exp) begin errors++; $display("FAIL mid_new[%0d] got=%0d exp=%0d", k, desired_load, exp); end
    end
  endtask

  task automatic test_sign();
    int vals [18] = '{20, 20, 20, 20, -20, 20, -20, 0, 0, 0, -20, -20, -20, 16, 16, 16, 17, 17};
    logic exps [18] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 18; i++) begin
      pulse_sample(vals[i]);
      checks++; if (current_sign !== exps[i]) begin errors++; $display("FAIL sign[%0d] sample=%0d got=%0b exp=%0b", i, vals[i], current_sign, exps[i]); end
    end
    pulse_sample(17);
    checks++; if (current_sign !== 1'b1) begin errors++; $display("FAIL sign_edge17 got=%0b exp=1", current_sign); end
  endtask

  task automatic test_disable_reset();
    do_reset();
    send_duty(10, 3, 3);
    enable = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    checks++; if (desired_load !== C_LBB) begin errors++; $display("FAIL dis_cnt5 got=%0d exp=%0d", desired_load, C_LBB); end
    enable = 1'b0;
    step();
    checks++; if (desired_load !== C_NUL || period_start !== 1'b0) begin errors++; $display("FAIL dis_nul got=%0d/%0b exp=%0d/0", desired_load, period_start, C_NUL); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (desired_load !== C_NUL) begin errors++; $display("FAIL dis_hold[%0d] got=%0d exp=%0d", k, desired_load, C_NUL); end
    end
    enable = 1'b1;
    step();
    checks++; if (period_start !== 1'b1 || desired_load !== C_NUL) begin errors++; $display("FAIL dis_reentry got=%0b/%0d exp=1/%0d", period_start, desired_load, C_NUL); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (desired_load !== C_LAA) begin errors++; $display("FAIL dis_restart[%0d] got=%0d exp=%0d", k, desired_load, C_LAA); end
    end
    period = PW'(10);
    duty_a = PW'(4);
    duty_b = PW'(4);
    duty_valid = 1'b1;
    isample = SW'(20);
    isample_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    step();
    step();
    isample_valid = 1'b0;
    checks++; if (current_sign !== 1'b1) begin errors++; $display("FAIL pre_rst_sign got=%0b exp=1", current_sign); end
    step();
    checks++; if (duty_ready !== 1'b0 || desired_load !== C_LCC) begin errors++; $display("FAIL pre_rst_state got=%0b/%0d exp=0/%0d", duty_ready, desired_load, C_LCC); end
    rst = 1'b1;
    #1;
    checks++; if (desired_load !== C_NUL) begin errors++; $display("FAIL arst_load got=%0d exp=%0d", desired_load, C_NUL); end
    checks++; if (current_sign !== 1'b0) begin errors++; $display("FAIL arst_sign got=%0b exp=0", current_sign); end
    checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%0b exp=1", duty_ready); end
    checks++; if (period_start !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL arst_pulses got=%0b/%0b exp=0/0", period_start, fault); end
    step();
    rst = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_skip_reject();
    test_mid_update();
    test_sign();
    test_disable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
